pipe_hazard_ctrl: RTL

// Centralised stall/flush/clock-enable controller for the 5-stage pipeline (IF,ID,EXE,MEM,WB).

---
 rtl/pipe_hazard_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/clock-enable controller for a 5-stage pipeline with ISR drain and spin gating
module pipe_hazard_ctrl #(
  parameter int NMC         = 2,
  parameter int CNT_W       = 32,
  parameter int SPIN_THRESH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             hzd_jalr,
  input  logic             hzd_load_a,
  input  logic             hzd_load_b,
  input  logic [NMC-1:0]   mc_busy,
  input  logic             branch_flush,
  input  logic             jump_flush,
  input  logic             self_jump,
  input  logic             isr_req,
  input  logic             wake,
  input  logic             cnt_clr,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic             clk_en_fe,
  output logic             isr_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int SW = $clog2(SPIN_THRESH + 1);
  localparam logic [SW-1:0] SPIN_MAX = SW'(SPIN_THRESH);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_SPIN} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_spin, w_spin_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic [4:0] w_stall, w_flush;
  logic w_ld, w_mc, w_jh, w_clk_en, w_ack;
  assign w_ld = hzd_load_a | hzd_load_b;
  assign w_mc = |mc_busy;
  assign w_jh = hzd_jalr;
  always_comb begin
    w_stall  = {2'b00, w_ld | w_mc, {2{w_ld | w_jh | w_mc}}};
    w_flush  = {1'b0, w_ld | w_mc, w_jh | branch_flush, jump_flush | branch_flush, 1'b0};
    w_clk_en = 1'b1;
    w_ack    = 1'b0;
    w_next   = r_state;
    case (r_state)
      S_IDLE:  w_next = isr_req ? S_DRAIN : (w_spin_nxt == SPIN_MAX ? S_SPIN : S_IDLE);
      S_DRAIN: begin
        w_stall[0] = 1'b1;
        w_next     = (!w_ld && !w_jh && !w_mc) ? S_FLUSH : S_DRAIN;
      end
      S_FLUSH: begin
        w_stall = '0;
        w_flush = 5'b00111;
        w_ack   = 1'b1;
        w_next  = S_IDLE;
      end
      default: begin
        w_stall  = 5'b00111;
        w_flush  = '0;
        w_clk_en = 1'b0;
        w_next   = isr_req ? S_DRAIN : (wake ? S_IDLE : S_SPIN);
      end
    endcase
  end
  // Spin count only advances on unstalled self-jumps; a self-jump's own redirect flush must not clear it.
  always_comb begin
    w_spin_nxt = r_spin;
    if (r_state == S_FLUSH || (r_state == S_SPIN && !isr_req && wake))
      w_spin_nxt = '0;
    else if (r_state == S_IDLE) begin
      if (!self_jump && (!(w_ld | w_mc) || branch_flush || jump_flush))
        w_spin_nxt = '0;
      else if (self_jump && !(w_ld | w_mc) && r_spin != SPIN_MAX)
        w_spin_nxt = r_spin + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_spin      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_spin      <= w_spin_nxt;
      r_stall_cnt <= cnt_clr ? '0 : r_stall_cnt + CNT_W'(w_stall[1] && !(&r_stall_cnt));
      r_flush_cnt <= cnt_clr ? '0 : r_flush_cnt + CNT_W'((w_flush[1] | w_flush[2]) && !(&r_flush_cnt));
    end
  end
  assign stall     = nrst ? w_stall : '0;
  assign flush     = nrst ? w_flush : '0;
  assign clk_en_fe = !nrst | w_clk_en;
  assign isr_ack   = nrst & w_ack;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule
